i2c_txn_arbiter: RTL and testbench

//  Shares one I2C_master1 instance between NUM_REQ requesters via round-robin arbitration.
//  - Latches the winner's transaction fields and launches the master with a one-cycle enable.
//  - Waits for master completion, then returns read data and status to the winner.
//  - Sits between the register/sensor client blocks and I2C_master1. Owns the master's

---
 rtl/i2c_txn_arbiter.sv | 161 ++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C_master1 between NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_slave_addr,
  input  logic [8*NUM_REQ-1:0] req_reg_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic                 timeout,
  output logic                 m_enable,
  output logic [6:0]           m_slave_addr,
  output logic [7:0]           m_reg_addr,
  output logic [7:0]           m_data_in,
  output logic                 m_read_write,
  input  logic                 m_done,
  input  logic                 m_nack,
  input  logic [7:0]           m_rdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic            wd_expire;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [PW-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdog;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog <= '0;
    end else if (state == S_WAIT && !m_done) begin
      wdog <= wdog + WW'(1);
    end else begin
      wdog <= '0;
    end
  end

  // m_done in the limit cycle takes priority over the watchdog.
  assign wd_expire = (state == S_WAIT) && !m_done && (wdog == WW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign wd_expire          = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (pick_valid) state_nx = S_GRANT;
      S_GRANT:  state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT:   if (m_done || wd_expire) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    m_enable = (state == S_LAUNCH);
    done     = (state == S_DONE) ? gnt : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt          <= '0;
      gnt_idx      <= '0;
      rr_ptr       <= '0;
      rdata        <= '0;
      err          <= 1'b0;
      m_slave_addr <= '0;
      m_reg_addr   <= '0;
      m_data_in    <= '0;
      m_read_write <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt     <= NUM_REQ'(1) << pick_idx;
            gnt_idx <= pick_idx;
          end
        end
        S_GRANT: begin
          m_read_write <= req_rw[gnt_idx];
          m_slave_addr <= req_slave_addr[7*gnt_idx +: 7];
          m_reg_addr   <= req_reg_addr[8*gnt_idx +: 8];
          m_data_in    <= req_wdata[8*gnt_idx +: 8];
        end
        S_WAIT: begin
          if (m_done) begin
            rdata   <= m_rdata;
            err     <= m_nack;
`ifdef I2C_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end else if (wd_expire) begin
            rdata   <= '0;
            err     <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
            timeout <= 1'b1;
`endif
          end
        end
        S_DONE: begin
          gnt    <= '0;
          rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter; a small task stands in for I2C_master1.
`timescale 1ns/1ps
module tb_i2c_txn_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_rw;
  logic [7*N-1:0] req_slave_addr;
  logic [8*N-1:0] req_reg_addr, req_wdata;
  logic [N-1:0]   gnt, done;
  logic [7:0]     rdata;
  logic           err, timeout, m_enable;
  logic [6:0]     m_slave_addr;
  logic [7:0]     m_reg_addr, m_data_in;
  logic           m_read_write;
  logic           m_done, m_nack;
  logic [7:0]     m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
    .req_slave_addr(req_slave_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err), .timeout(timeout),
    .m_enable(m_enable), .m_slave_addr(m_slave_addr), .m_reg_addr(m_reg_addr),
    .m_data_in(m_data_in), .m_read_write(m_read_write),
    .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int i, input logic rw, input logic [6:0] sa,
                            input logic [7:0] ra, input logic [7:0] wd);
    req_rw[i]               = rw;
    req_slave_addr[7*i +: 7] = sa;
    req_reg_addr[8*i +: 8]   = ra;
    req_wdata[8*i +: 8]      = wd;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Master model: wait for the start pulse, record it, complete after lat cycles.
  task automatic master_serve(input int lat, input logic nack, input logic [7:0] rd,
                              output logic [N-1:0] g_en, output logic [6:0] sa,
                              output logic [7:0] ra, output logic [7:0] wd, output logic rw,
                              output logic [N-1:0] d_seen, output int d_wait, output int pulses);
    g_en = '0; sa = '0; ra = '0; wd = '0; rw = 1'b0; d_seen = '0; d_wait = -1; pulses = 0;
    for (int k = 0; k < 20 && !m_enable; k++) step();
    if (!m_enable) return;
    g_en = gnt; sa = m_slave_addr; ra = m_reg_addr; wd = m_data_in; rw = m_read_write;
    pulses = 1;
    for (int k = 0; k < lat; k++) begin
      step();
      if (m_enable) pulses++;
    end
    m_done = 1'b1; m_nack = nack; m_rdata = rd;
    step();
    m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'hEE;
    d_wait = 0;
    for (int k = 0; k < 4 && done == '0; k++) begin
      step();
      d_wait++;
    end
    d_seen = done;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req = '0; req_rw = '0; req_slave_addr = '0; req_reg_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
    step(); step();
    n_cmp++;
    if ({gnt, done, rdata, err, timeout, m_enable, m_slave_addr, m_reg_addr, m_data_in, m_read_write} !== '0) begin
      n_bad++;
      $display("FAIL reset_held: gnt=%b done=%b rdata=%h err=%b to=%b en=%b expected all 0",
               gnt, done, rdata, err, timeout, m_enable);
    end
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if ({gnt, done, err, timeout, m_enable} !== '0) begin
        n_bad++;
        $display("FAIL reset_idle cyc%0d: gnt=%b done=%b err=%b to=%b en=%b expected all 0",
                 k, gnt, done, err, timeout, m_enable);
      end
    end
  endtask

  task automatic test_single_write;
    logic [N-1:0] g_en, d_seen;
    logic [6:0] sa; logic [7:0] ra, wd; logic rw; int d_wait, pulses;
    set_fields(1, 1'b0, 7'h69, 8'h1A, 8'hC3);
    req = 4'b0010;
    step();
    n_cmp++;
    if (gnt !== 4'b0010 || m_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL write_grant_latency: gnt=%b en=%b expected 0010/0", gnt, m_enable);
    end
    step();
    master_serve(20, 1'b0, 8'h77, g_en, sa, ra, wd, rw, d_seen, d_wait, pulses);
    n_cmp++;
    if ({sa, ra, wd, rw} !== {7'h69, 8'h1A, 8'hC3, 1'b0} || pulses != 1 || g_en !== 4'b0010) begin
      n_bad++;
      $display("FAIL write_launch: sa=%h ra=%h wd=%h rw=%b pulses=%0d gnt=%b expected 69/1a/c3/0 1 0010",
               sa, ra, wd, rw, pulses, g_en);
    end
    n_cmp++;
    if (d_seen !== 4'b0010 || d_wait != 0 || err !== 1'b0 || gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL write_done: done=%b wait=%0d err=%b gnt=%b expected 0010 0 0 0010",
               d_seen, d_wait, err, gnt);
    end
    req = '0;
    step();
    n_cmp++;
    if (gnt !== '0 || done !== '0) begin
      n_bad++;
      $display("FAIL write_release: gnt=%b done=%b expected 0/0", gnt, done);
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] g_en, d_seen, exp;
    logic [6:0] sa; logic [7:0] ra, wd; logic rw; int d_wait, pulses;
    do_reset();
    for (int i = 0; i < N; i++) set_fields(i, 1'b0, 7'(16 + i), 8'(32 + i), 8'(48 + i));
    req = 4'b1111;
    step();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL rr_first: gnt=%b expected 0001", gnt);
    end
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % N);
      master_serve(3 + i, 1'b0, 8'h30, g_en, sa, ra, wd, rw, d_seen, d_wait, pulses);
      n_cmp++;
      if (d_seen !== exp || d_wait != 0 || g_en !== exp || sa !== 7'(16 + i % N) || pulses != 1) begin
        n_bad++;
        $display("FAIL rr_txn%0d: done=%b gnt=%b sa=%h pulses=%0d expected %b %b %h 1",
                 i, d_seen, g_en, sa, pulses, exp, exp, 7'(16 + i % N));
      end
      if (i == 4) req = '0;
      step();
      n_cmp++;
      if (gnt !== '0 || done !== '0) begin
        n_bad++;
        $display("FAIL rr_idle_gap%0d: gnt=%b done=%b expected 0/0", i, gnt, done);
      end
      if (i < 4) begin
        step();
        n_cmp++;
        if (gnt !== (4'b0001 << ((i + 1) % N))) begin
          n_bad++;
          $display("FAIL rr_next%0d: gnt=%b expected %b", i, gnt, 4'b0001 << ((i + 1) % N));
        end
      end
    end
  endtask

  task automatic test_read_nack;
    logic [N-1:0] g_en, d_seen;
    logic [6:0] sa; logic [7:0] ra, wd; logic rw; int d_wait, pulses;
    set_fields(2, 1'b1, 7'h2B, 8'h44, 8'h00);
    req = 4'b0100;
    master_serve(5, 1'b1, 8'h5A, g_en, sa, ra, wd, rw, d_seen, d_wait, pulses);
    n_cmp++;
    if (d_seen !== 4'b0100 || rdata !== 8'h5A || err !== 1'b1 || timeout !== 1'b0 || rw !== 1'b1) begin
      n_bad++;
      $display("FAIL read_done: done=%b rdata=%h err=%b to=%b rw=%b expected 0100 5a 1 0 1",
               d_seen, rdata, err, timeout, rw);
    end
    req = '0;
    step();
    n_cmp++;
    if (rdata !== 8'h5A || err !== 1'b1 || done !== '0) begin
      n_bad++;
      $display("FAIL read_hold: rdata=%h err=%b done=%b expected 5a 1 0", rdata, err, done);
    end
  endtask

  task automatic test_reset_mid_txn;
    logic [N-1:0] g_en, d_seen;
    logic [6:0] sa; logic [7:0] ra, wd; logic rw; int d_wait, pulses;
    set_fields(2, 1'b0, 7'h33, 8'h55, 8'h99);
    req = 4'b0100;
    for (int k = 0; k < 20 && !m_enable; k++) step();
    step(); step(); step();
    n_cmp++;
    if (gnt !== 4'b0100 || m_slave_addr !== 7'h33) begin
      n_bad++;
      $display("FAIL midrst_setup: gnt=%b sa=%h expected 0100 33", gnt, m_slave_addr);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, done, m_enable, m_slave_addr, m_reg_addr, m_data_in, m_read_write} !== '0) begin
      n_bad++;
      $display("FAIL midrst_clear: gnt=%b done=%b sa=%h ra=%h wd=%h expected all 0",
               gnt, done, m_slave_addr, m_reg_addr, m_data_in);
    end
    req = '0;
    step();
    reset = 1'b1;
    step(); step();
    n_cmp++;
    if (gnt !== '0 || m_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_no_replay: gnt=%b en=%b expected 0/0", gnt, m_enable);
    end
    for (int i = 0; i < N; i++) set_fields(i, 1'b1, 7'(8 + i), 8'h00, 8'h00);
    req = 4'b1111;
    step();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL midrst_rr_ptr: gnt=%b expected 0001", gnt);
    end
    master_serve(3, 1'b0, 8'hA5, g_en, sa, ra, wd, rw, d_seen, d_wait, pulses);
    n_cmp++;
    if (d_seen !== 4'b0001 || rdata !== 8'hA5 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_after: done=%b rdata=%h err=%b expected 0001 a5 0", d_seen, rdata, err);
    end
    req = '0;
    step(); step();
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout;
    set_fields(0, 1'b1, 7'h11, 8'h22, 8'h00);
    req = 4'b0001;
    step(); step();
    n_cmp++;
    if (m_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL to_launch: en=%b expected 1", m_enable);
    end
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 16) begin
        n_cmp++;
        if (done !== '0) begin
          n_bad++;
          $display("FAIL to_early: done=%b expected 0", done);
        end
      end
    end
    n_cmp++;
    if (done !== 4'b0001 || err !== 1'b1 || timeout !== 1'b1 || rdata !== 8'h00) begin
      n_bad++;
      $display("FAIL to_done: done=%b err=%b to=%b rdata=%h expected 0001 1 1 00",
               done, err, timeout, rdata);
    end
    req = '0;
    step();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_nack();
    test_reset_mid_txn();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
